v74x148_irq: RTL



---
 rtl/v74x148_irq.sv | 105 ++++++++++
 1 files changed

// File: rtl/v74x148_irq.sv
// Clocked 74x148-style priority encoder: requests latch into a pending register and the
// highest-priority one is presented on A_L/GS_L until ACK, followed by a one-cycle gap.
module v74x148_irq #(
  parameter bit EDGE = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EI_L,
  input  logic [7:0] I_L,
  input  logic       ACK,
  output logic [2:0] A_L,
  output logic       GS_L,
  output logic       EO_L
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] pend_q, pend_d;
  logic [7:0] prev_q;
  logic [2:0] code_q;
  logic [2:0] a_l_q;
  logic       gs_l_q;
  logic [7:0] set_vec;
  logic [7:0] clr_vec;
  logic       ack_hit;

  function automatic logic [2:0] prio_enc(input logic [7:0] req);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (req[k]) idx = 3'(k);
    end
    return idx;
  endfunction

  // Edge mode only fires on a 1->0 step seen against the previous sample.
  always_comb begin
    if (EDGE) set_vec = prev_q & ~I_L;
    else      set_vec = ~I_L;
  end

  assign ack_hit = (state_q == PRESENT) && ACK;

  always_comb begin
    clr_vec = 8'h00;
    if (ack_hit) clr_vec[code_q] = 1'b1;
    // Set is OR'd last so a simultaneous set on the acknowledged bit wins.
    pend_d = (pend_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_q <= 8'h00;
      prev_q <= 8'hFF;
    end else begin
      pend_q <= pend_d;
      prev_q <= I_L;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      code_q  <= 3'd0;
      a_l_q   <= 3'b111;
      gs_l_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!EI_L && (pend_q != 8'h00)) begin
            code_q  <= prio_enc(pend_q);
            a_l_q   <= ~prio_enc(pend_q);
            gs_l_q  <= 1'b0;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (ACK) begin
            a_l_q   <= 3'b111;
            gs_l_q  <= 1'b1;
            state_q <= GAP;
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          a_l_q   <= 3'b111;
          gs_l_q  <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign A_L  = a_l_q;
  assign GS_L = gs_l_q;
  assign EO_L = ~(!EI_L && (pend_q == 8'h00) && (state_q == IDLE));

endmodule
